// File: rtl/router_sync_if.sv
// router_sync_if: groups the router FSM / FIFO handshake signals that pass
// through the router synchronizer.
//
// Signals
//   data_in[1:0]        destination address carried by the packet header
//   detect_add          FSM strobe, data_in holds a new address this cycle
//   write_enb_reg       FSM write request for the current packet
//   read_enb_0/1/2      downstream read enable of FIFO 0/1/2
//   empty_0/1/2         FIFO 0/1/2 empty flag
//   full_0/1/2          FIFO 0/1/2 full flag
//   vld_out_0/1/2       port x holds data
//   fifo_full           full flag of the currently addressed FIFO
//   soft_reset_0/1/2    one-cycle timeout pulse to FIFO x
//   write_enb[2:0]      one-hot write enable, bit x -> FIFO x
//
// Modports
//   master : the environment (FSM, FIFOs, downstream readers)
//   slave  : the synchronizer itself
interface router_sync_if;
  logic [1:0] data_in;
  logic       detect_add;
  logic       write_enb_reg;
  logic       read_enb_0;
  logic       read_enb_1;
  logic       read_enb_2;
  logic       empty_0;
  logic       empty_1;
  logic       empty_2;
  logic       full_0;
  logic       full_1;
  logic       full_2;
  logic       vld_out_0;
  logic       vld_out_1;
  logic       vld_out_2;
  logic       fifo_full;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic [2:0] write_enb;

  modport master (
    output data_in, detect_add, write_enb_reg,
    output read_enb_0, read_enb_1, read_enb_2,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  fifo_full,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  write_enb
  );

  modport slave (
    input  data_in, detect_add, write_enb_reg,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    output vld_out_0, vld_out_1, vld_out_2,
    output fifo_full,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output write_enb
  );
endinterface

// File: rtl/router_sync.sv
// router_sync: synchronizer between the 1x3 router FSM and its three output
// FIFOs.
//   - latches the destination address when the FSM strobes detect_add
//   - steers the FSM write request to the addressed FIFO (one-hot write_enb)
//   - returns the addressed FIFO's full flag as fifo_full
//   - drives vld_out_x = ~empty_x
//   - per port, pulses soft_reset_x for one cycle when valid data has sat
//     unread for TIMEOUT consecutive clocks
//
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : router_sync_if.slave, all handshake / flag signals
//
// Parameters
//   TIMEOUT : unread-valid cycles before a soft reset pulse (>= 2)
//   CNT_W   : width of each timeout counter (must hold TIMEOUT-1)
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input logic          clk,
  input logic          rst,
  router_sync_if.slave bus
);

  localparam logic [1:0] ADDR_P0  = 2'd0;
  localparam logic [1:0] ADDR_P1  = 2'd1;
  localparam logic [1:0] ADDR_P2  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Address register
  logic [1:0] addr_q;
  logic [1:0] addr_d;

  // Per-port flag vectors, bit x belongs to port x
  logic [2:0] vld_s;
  logic [2:0] rd_s;
  logic [2:0] full_s;

  // Steering results
  logic [2:0] write_enb_s;
  logic       fifo_full_s;

  // Timeout counters and pulse registers
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       srst_q;
  logic [2:0]       srst_d;

  assign vld_s  = ~{bus.empty_2, bus.empty_1, bus.empty_0};
  assign rd_s   = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
  assign full_s = {bus.full_2, bus.full_1, bus.full_0};

  // Next address: capture the header address on detect_add, else hold
  always_comb begin
    addr_d = addr_q;
    if (bus.detect_add) begin
      addr_d = bus.data_in;
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= 2'b00;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Write-enable decode; uses the registered address so a detect_add in the
  // same cycle as a write still steers to the previous packet's FIFO
  always_comb begin
    write_enb_s = 3'b000;
    if (bus.write_enb_reg) begin
      case (addr_q)
        ADDR_P0: write_enb_s = 3'b001;
        ADDR_P1: write_enb_s = 3'b010;
        ADDR_P2: write_enb_s = 3'b100;
        default: write_enb_s = 3'b000;
      endcase
    end else begin
      write_enb_s = 3'b000;
    end
  end

  // Full-flag select; the invalid address 3 never reports full
  always_comb begin
    fifo_full_s = 1'b0;
    case (addr_q)
      ADDR_P0: fifo_full_s = full_s[0];
      ADDR_P1: fifo_full_s = full_s[1];
      ADDR_P2: fifo_full_s = full_s[2];
      default: fifo_full_s = 1'b0;
    endcase
  end

  // Timeout next-state: count consecutive unread-valid cycles per port and
  // fire one pulse when the count reaches TIMEOUT, then start over
  always_comb begin
    for (int x = 0; x < 3; x++) begin
      cnt_d[x]  = CNT_ZERO;
      srst_d[x] = 1'b0;
      if (!vld_s[x]) begin
        cnt_d[x]  = CNT_ZERO;
        srst_d[x] = 1'b0;
      end else if (rd_s[x]) begin
        cnt_d[x]  = CNT_ZERO;
        srst_d[x] = 1'b0;
      end else if (cnt_q[x] == CNT_LAST) begin
        cnt_d[x]  = CNT_ZERO;
        srst_d[x] = 1'b1;
      end else begin
        cnt_d[x]  = cnt_q[x] + CNT_ONE;
        srst_d[x] = 1'b0;
      end
    end
  end

  // Timeout counters and soft-reset pulse registers, asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int x = 0; x < 3; x++) begin
        cnt_q[x] <= CNT_ZERO;
      end
      srst_q <= 3'b000;
    end else begin
      for (int x = 0; x < 3; x++) begin
        cnt_q[x] <= cnt_d[x];
      end
      srst_q <= srst_d;
    end
  end

  assign bus.write_enb    = write_enb_s;
  assign bus.fifo_full    = fifo_full_s;
  assign bus.vld_out_0    = vld_s[0];
  assign bus.vld_out_1    = vld_s[1];
  assign bus.vld_out_2    = vld_s[2];
  assign bus.soft_reset_0 = srst_q[0];
  assign bus.soft_reset_1 = srst_q[1];
  assign bus.soft_reset_2 = srst_q[2];

endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync: self-checking bench for router_sync. A behavioural model
// tracks the latched address and the unbounded run length of unread-valid
// cycles per port; a compare process checks every DUT output against it on
// each falling edge. Directed sequences add literal expectations.
module tb_router_sync;

  localparam int TIMEOUT = 30;

  logic       clk;
  logic       rst;
  logic [1:0] data_in;
  logic       detect_add;
  logic       write_enb_reg;
  logic [2:0] empty_v;
  logic [2:0] full_v;
  logic [2:0] rd_v;

  int checks;
  int errors;

  router_sync_if bus();

  assign bus.data_in       = data_in;
  assign bus.detect_add    = detect_add;
  assign bus.write_enb_reg = write_enb_reg;
  assign bus.read_enb_0    = rd_v[0];
  assign bus.read_enb_1    = rd_v[1];
  assign bus.read_enb_2    = rd_v[2];
  assign bus.empty_0       = empty_v[0];
  assign bus.empty_1       = empty_v[1];
  assign bus.empty_2       = empty_v[2];
  assign bus.full_0        = full_v[0];
  assign bus.full_1        = full_v[1];
  assign bus.full_2        = full_v[2];

  router_sync #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [1:0] addr_m;
  int         run_m [3];
  logic [2:0] sr_m;

  // Behavioural model: address capture and unread-run tracking
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_m <= 2'd0;
      sr_m   <= 3'b000;
      for (int i = 0; i < 3; i++) run_m[i] <= 0;
    end else begin
      if (detect_add) addr_m <= data_in;
      for (int i = 0; i < 3; i++) begin
        if (!empty_v[i] && !rd_v[i]) begin
          run_m[i] <= run_m[i] + 1;
          sr_m[i]  <= ((run_m[i] + 1) % TIMEOUT) == 0;
        end else begin
          run_m[i] <= 0;
          sr_m[i]  <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model on each falling edge
  always @(negedge clk) begin
    logic [2:0] we_e;
    logic       ff_e;
    we_e = 3'b000;
    ff_e = 1'b0;
    if (write_enb_reg && addr_m != 2'd3) we_e = 3'b001 << addr_m;
    if (addr_m != 2'd3) ff_e = full_v[addr_m];
    chk("cmp_write_enb", {5'd0, bus.write_enb}, {5'd0, we_e});
    chk("cmp_fifo_full", {7'd0, bus.fifo_full}, {7'd0, ff_e});
    chk("cmp_vld_out", {5'd0, bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, {5'd0, ~empty_v});
    chk("cmp_soft_reset", {5'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, {5'd0, sr_m});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Run n edges, record the edge index of the first pulse on port p and the
  // number of pulse cycles seen
  task automatic run_edges(input int n, input int p, output int first, output int second, output int npulse);
    logic [2:0] sr;
    first  = 0;
    second = 0;
    npulse = 0;
    for (int k = 1; k <= n; k++) begin
      cyc();
      #1;
      sr = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      if (sr[p]) begin
        npulse++;
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
    end
  endtask

  initial begin
    int f, s, n;
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    data_in       = 2'd0;
    detect_add    = 1'b0;
    write_enb_reg = 1'b0;
    empty_v       = 3'b111;
    full_v        = 3'b001;
    rd_v          = 3'b000;

    // Reset state
    #3;
    chk("rst_write_enb", {5'd0, bus.write_enb}, 8'h00);
    chk("rst_fifo_full", {7'd0, bus.fifo_full}, 8'h01);
    chk("rst_soft_reset", {5'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, 8'h00);
    cyc();
    rst = 1'b1;
    full_v = 3'b000;
    cyc();

    // Address 2 steering
    data_in = 2'd2; detect_add = 1'b1;
    cyc();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    #1 chk("addr2_we", {5'd0, bus.write_enb}, 8'h04);
    full_v = 3'b100;
    #1 chk("addr2_full_set", {7'd0, bus.fifo_full}, 8'h01);
    full_v = 3'b000;
    #1 chk("addr2_full_clr", {7'd0, bus.fifo_full}, 8'h00);
    cyc();

    // Invalid address 3
    data_in = 2'd3; detect_add = 1'b1;
    cyc();
    detect_add = 1'b0; full_v = 3'b111;
    #1 chk("addr3_we", {5'd0, bus.write_enb}, 8'h00);
    chk("addr3_full", {7'd0, bus.fifo_full}, 8'h00);
    cyc();

    // Address 0
    data_in = 2'd0; detect_add = 1'b1;
    cyc();
    detect_add = 1'b0; full_v = 3'b001;
    #1 chk("addr0_we", {5'd0, bus.write_enb}, 8'h01);
    chk("addr0_full_set", {7'd0, bus.fifo_full}, 8'h01);
    full_v = 3'b110;
    #1 chk("addr0_full_clr", {7'd0, bus.fifo_full}, 8'h00);
    cyc();

    // Address 1
    data_in = 2'd1; detect_add = 1'b1;
    cyc();
    detect_add = 1'b0; full_v = 3'b010;
    #1 chk("addr1_we", {5'd0, bus.write_enb}, 8'h02);
    chk("addr1_full_set", {7'd0, bus.fifo_full}, 8'h01);
    full_v = 3'b101;
    #1 chk("addr1_full_clr", {7'd0, bus.fifo_full}, 8'h00);
    cyc();

    // detect_add during a write: decode stays on the old address this cycle
    data_in = 2'd0; detect_add = 1'b1;
    #1 chk("simul_old_addr", {5'd0, bus.write_enb}, 8'h02);
    cyc();
    detect_add = 1'b0;
    #1 chk("simul_new_addr", {5'd0, bus.write_enb}, 8'h01);
    full_v = 3'b000;

    // Valid outputs: empty_0=1, empty_1=1, empty_2=0; port 2 read meanwhile
    rd_v = 3'b100;
    empty_v = 3'b011;
    #1 chk("vld_pattern", {5'd0, bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, 8'h04);
    cyc();

    // Port 2 timeout: pulses after edge 30 and edge 60, one cycle each
    rd_v = 3'b000;
    run_edges(65, 2, f, s, n);
    chk("p2_first_pulse", 8'(f), 8'd30);
    chk("p2_second_pulse", 8'(s), 8'd60);
    chk("p2_pulse_cycles", 8'(n), 8'd2);
    empty_v = 3'b111;
    cyc();

    // Port 1: read at count 20 restarts the count
    empty_v = 3'b101;
    run_edges(20, 1, f, s, n);
    chk("p1_no_early_pulse", 8'(n), 8'd0);
    rd_v = 3'b010;
    cyc();
    rd_v = 3'b000;
    run_edges(35, 1, f, s, n);
    chk("p1_restart_pulse", 8'(f), 8'd30);

    // Port 1: asynchronous reset mid-count clears counter and address
    run_edges(10, 1, f, s, n);
    rst = 1'b0;
    #1 chk("midrst_soft_reset", {5'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, 8'h00);
    chk("midrst_we_addr0", {5'd0, bus.write_enb}, 8'h01);
    cyc();
    rst = 1'b1;
    run_edges(35, 1, f, s, n);
    chk("midrst_pulse_after_30", 8'(f), 8'd30);
    chk("midrst_pulse_cycles", 8'(n), 8'd1);

    empty_v = 3'b111;
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
